nios_oci_dct_trace_monitor: RTL

Parametrised trace-capture monitor for the Nios II OCI debug trace path, the functional successor to the per-core OCI test-bench hook in the nios_system hierarchy. Accepts trace words (`dct_buffer`) with their slot counts (`dct_count`) and buffers them in a show-ahead FIFO for a downstream reader. Keeps saturating frame/slot statistics and sticky error flags, and sequences the end-of-test drain on `test_ending` / `test_has_ended`. One instance per Nios core group.

---
 rtl/nios_oci_dct_trace_monitor.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/nios_oci_dct_trace_monitor.sv
// nios_oci_dct_trace_monitor
// Trace-capture monitor for the Nios II OCI debug trace path. Buffers
// {dct_count, dct_buffer} words in a show-ahead FIFO, keeps saturating
// frame/slot statistics and sticky error flags, and sequences the
// end-of-test drain/flush.
// Optional feature macro: OCI_TRACE_CHECKSUM_EN (running rotate-XOR checksum
// of accepted trace words). When undefined, checksum is tied to zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | out of reset, nothing accepted yet
// RUN   | accepting trace words
// DRAIN | graceful end: writes ignored, reader empties the FIFO
// ENDED | test over; holds until reset

module nios_oci_dct_trace_monitor #(
  parameter int DCT_W  = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int STAT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     dct_valid,
  input  logic [DCT_W-1:0]         dct_buffer,
  input  logic [CNT_W-1:0]         dct_count,
  input  logic                     test_ending,
  input  logic                     test_has_ended,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DCT_W+CNT_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [STAT_W-1:0]        frame_cnt,
  output logic [STAT_W-1:0]        slot_cnt,
  output logic                     overflow,
  output logic                     empty_frame,
  output logic [1:0]               state,
  output logic                     done,
  output logic [DCT_W-1:0]         checksum
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int ENT_W = DCT_W + CNT_W;
  localparam int SUM_W = ((STAT_W > CNT_W) ? STAT_W : CNT_W) + 1;

  localparam logic [LW-1:0]     FULL_LVL = LW'(DEPTH);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ENDED = 2'd3
  } state_t;

  state_t             cur_state;
  state_t             state_next;

  logic [ENT_W-1:0]   mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr_inc;
  logic [ENT_W-1:0]   new_entry;
  logic [ENT_W-1:0]   head_next;
  logic [LW-1:0]      level_next;

  logic               flush;
  logic               pop;
  logic               wr_open;
  logic               push;
  logic               drop;

  logic [STAT_W-1:0]  frame_inc;
  logic [SUM_W-1:0]   slot_sum;
  logic [STAT_W-1:0]  slot_sat;

  assign state = cur_state;

  // Decode push/pop/flush, next FIFO occupancy, next head entry and next state.
  always_comb begin
    flush      = test_has_ended && (cur_state != ENDED);
    pop        = rd_valid && rd_ready;
    wr_open    = dct_valid && !flush && ((cur_state == IDLE) || (cur_state == RUN));
    push       = wr_open && ((fifo_level != FULL_LVL) || pop);
    drop       = wr_open && (fifo_level == FULL_LVL) && !pop;
    rd_ptr_inc = rd_ptr + 1'b1;
    new_entry  = {dct_count, dct_buffer};

    level_next = fifo_level;
    if (flush)             level_next = '0;
    else if (push && !pop) level_next = fifo_level + 1'b1;
    else if (pop && !push) level_next = fifo_level - 1'b1;

    // Head register tracks the oldest entry; it holds its last value when empty.
    head_next = rd_data;
    if (!flush) begin
      if (push && (fifo_level == '0))
        head_next = new_entry;
      else if (pop && push && (fifo_level == LW'(1)))
        head_next = new_entry;
      else if (pop && (fifo_level > LW'(1)))
        head_next = mem[rd_ptr_inc];
    end

    state_next = cur_state;
    case (cur_state)
      IDLE: begin
        if (flush)            state_next = ENDED;
        else if (test_ending) state_next = DRAIN;
        else if (push)        state_next = RUN;
      end
      RUN: begin
        if (flush)            state_next = ENDED;
        else if (test_ending) state_next = DRAIN;
      end
      DRAIN: begin
        if (flush || (level_next == '0)) state_next = ENDED;
      end
      default: state_next = ENDED;
    endcase

    frame_inc = (frame_cnt == STAT_MAX) ? frame_cnt : frame_cnt + 1'b1;
    slot_sum  = SUM_W'(slot_cnt) + SUM_W'(dct_count);
    slot_sat  = (slot_sum > SUM_W'(STAT_MAX)) ? STAT_MAX : slot_sum[STAT_W-1:0];
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (reset_n && push)
      mem[wr_ptr] <= new_entry;
  end

  // FSM, FIFO pointers/level, head register, statistics and sticky flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_state   <= IDLE;
      done        <= 1'b0;
      fifo_level  <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      frame_cnt   <= '0;
      slot_cnt    <= '0;
      overflow    <= 1'b0;
      empty_frame <= 1'b0;
    end else begin
      cur_state  <= state_next;
      done       <= (state_next == ENDED) && (cur_state != ENDED);
      fifo_level <= level_next;
      rd_valid   <= (level_next != '0);
      rd_data    <= head_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr_inc;
      end
      if (push) begin
        frame_cnt <= frame_inc;
        slot_cnt  <= slot_sat;
        if (dct_count == '0) empty_frame <= 1'b1;
      end
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef OCI_TRACE_CHECKSUM_EN
  // Rotate-left-by-one then XOR each accepted word; survives the ENDED flush.
  always_ff @(posedge clk) begin
    if (!reset_n)
      checksum <= '0;
    else if (push)
      checksum <= {checksum[DCT_W-2:0], checksum[DCT_W-1]} ^ dct_buffer;
  end
`else
  assign checksum = '0;
`endif

endmodule
